wb_arbiter_2x1: RTL and testbench
=================================

// Module: wb_arbiter_2x1
// PURPOSE
//  Round-robin arbiter that shares one Wishbone slave port between two Wishbone masters.
//  Typical use: the CPU instruction bus (m0) and data bus (m1) sharing a single memory or peripheral.
//  Holds a grant for the whole bus cycle (while cyc stays high).
//  Aborts a hung slave access with a watchdog that returns err to the granted master.
// PARAMETERS
//  WB_ADDR_WIDTH  32  address width (AW)
//  WB_DATA_WIDTH  32  data width (DW); sel width is DW/8
//  TIMEOUT        256 watchdog limit in cycles of unacknowledged stb; 0 disables the watchdog
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     synchronous reset, active-high
//  mN_adr     in   AW    master N address (N=0,1; same for every mN_* line)
//  mN_dat_w   in   DW    master N write data
//  mN_sel     in   DW/8  master N byte selects
//  mN_we      in   1     master N write enable
//  mN_cyc     in   1     master N bus cycle request/hold
//  mN_stb     in   1     master N strobe
//  mN_dat_r   out  DW    read data to master N
//  mN_ack     out  1     ack to master N
//  mN_err     out  1     err to master N (slave err or watchdog)
//  s_adr/s_dat_w/s_sel/s_we/s_cyc/s_stb  out  AW/DW/DW8/1/1/1  muxed slave request
//  s_dat_r    in   DW    slave read data
//  s_ack      in   1     slave ack
//  s_err      in   1     slave err
//  gnt        out  2     one-hot current grant ({m1,m0}); 00 = idle
//  timeout    out  1     one-cycle pulse on a watchdog abort
// BEHAVIOUR
//  State machine: IDLE, GNT0, GNT1. Also holds last_gnt (1 bit) and the watchdog counter wd_cnt.
//  Widths: wd_cnt is $clog2(TIMEOUT+1) bits; last_gnt resets to 1 so m0 wins the first tie.
//  Reset (rst=1): next state IDLE, wd_cnt=0, last_gnt=1.
//  Reset outputs: while rst=1, force s_cyc, s_stb, mN_ack, mN_err, timeout, gnt all to 0.
//  IDLE: s_cyc=s_stb=0, no acks/errs, gnt=00.
//   - Only one mN_cyc=1: go to that GNTn.
//   - Both high: go to GNT of the master != last_gnt.
//   - On entry to GNTn: last_gnt <= n.
//  Arbitration latency: a request in IDLE reaches the slave 1 cycle later (registered grant).
//  GNTn request path, combinational passthrough: s_* = mN_* for the granted master.
//  GNTn response path: mN_dat_r = s_dat_r, mN_ack = s_ack, mN_err = s_err | wd_fire.
//  Non-granted master in GNTn: ack=err=0; dat_r=s_dat_r (don't-care).
//  Lock: GNTn holds while mN_cyc=1, across any number of stb beats. No preemption.
//  GNTn exit when mN_cyc=0:
//   - Other master's cyc=1: go directly to its GNT. One-cycle handoff, s_cyc=0 that cycle; last_gnt updated.
//   - Otherwise: go to IDLE.
//  Watchdog (TIMEOUT>0):
//   - In GNTn: wd_cnt increments while s_stb=1 && !s_ack && !s_err; otherwise clears to 0.
//   - wd_fire = (wd_cnt == TIMEOUT-1) && s_stb && !s_ack && !s_err.
//   - On wd_fire: mN_err=1 and timeout=1 for that cycle; s_cyc=s_stb=0 that cycle; wd_cnt clears.
//   - State is kept; the master may retry or drop cyc.
//  Watchdog simultaneous events: s_ack or s_err in the firing cycle wins, with no timeout pulse.
//  Watchdog disabled (TIMEOUT=0): counter held at 0, never fires.
//  Slave ack and err both high: pass both through unchanged; the slave is in protocol violation.
//  Reset mid-transfer: the transfer is dropped silently; no ack/err is generated.
// TESTING
//  1 m0 read only, s_ack at 2nd granted cycle, s_dat_r=32'hDEADBEEF -> gnt=01 one cycle after m0_cyc.
//    The m0_ack cycle equals the s_ack cycle and m0_dat_r=DEADBEEF; m1_ack stays 0.
//  2 Both cyc high out of reset -> m0 granted first.
//    m0 drops cyc -> s_cyc=0 one cycle, then gnt=10 with no IDLE visit.
//    Next tie -> gnt=01.
//  3 m1 holds cyc for 3 stb beats (ack each) while m0_cyc=1 -> gnt stays 10 throughout; m0_ack=0.
//    m0 granted the cycle after m1_cyc falls.
//  4 TIMEOUT=16, slave never acks m0 -> m0_err=timeout=1 on the 16th stb cycle with s_cyc=0 then.
//    wd_cnt=0 afterwards.
//  5 TIMEOUT=16, s_ack exactly on the 16th stb cycle -> m0_ack=1, m0_err=0, timeout=0.
//  6 rst=1 during GNT1 mid-beat -> all outputs 0 in that cycle; gnt=00 after.
//    A tie after reset grants m0.

Source files
------------

// File: rtl/wb_arbiter_2x1.sv
// Round-robin arbiter sharing one Wishbone slave between two masters.
// The grant is held for a whole bus cycle; a watchdog aborts hung slave accesses.
module wb_arbiter_2x1 #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   m0_adr,
  input  logic [WB_DATA_WIDTH-1:0]   m0_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] m0_sel,
  input  logic                       m0_we,
  input  logic                       m0_cyc,
  input  logic                       m0_stb,
  output logic [WB_DATA_WIDTH-1:0]   m0_dat_r,
  output logic                       m0_ack,
  output logic                       m0_err,
  input  logic [WB_ADDR_WIDTH-1:0]   m1_adr,
  input  logic [WB_DATA_WIDTH-1:0]   m1_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] m1_sel,
  input  logic                       m1_we,
  input  logic                       m1_cyc,
  input  logic                       m1_stb,
  output logic [WB_DATA_WIDTH-1:0]   m1_dat_r,
  output logic                       m1_ack,
  output logic                       m1_err,
  output logic [WB_ADDR_WIDTH-1:0]   s_adr,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0] s_sel,
  output logic                       s_we,
  output logic                       s_cyc,
  output logic                       s_stb,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_r,
  input  logic                       s_ack,
  input  logic                       s_err,
  output logic [1:0]                 gnt,
  output logic                       timeout
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_gnt;
  logic [WD_W-1:0]   r_wd_cnt;
  logic [WD_W-1:0]   w_wd_cnt_next;
  logic              w_busy;
  logic              w_sel1;
  logic              w_req_cyc;
  logic              w_req_stb;
  logic              w_hung;
  logic              w_wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wd_cnt   <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_wd_cnt <= w_wd_cnt_next;
      if (w_state_next == GNT0) begin
        r_last_gnt <= 1'b0;
      end else if (w_state_next == GNT1) begin
        r_last_gnt <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        // On a tie the master that did not win last time gets the bus.
        if (m0_cyc && m1_cyc) begin
          w_state_next = r_last_gnt ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          w_state_next = GNT0;
        end else if (m1_cyc) begin
          w_state_next = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          w_state_next = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          w_state_next = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_busy    = (r_state != IDLE);
  assign w_sel1    = (r_state == GNT1);
  assign w_req_cyc = w_busy && (w_sel1 ? m1_cyc : m0_cyc);
  assign w_req_stb = w_busy && (w_sel1 ? m1_stb : m0_stb);

  // A strobe the slave neither acks nor errs counts toward the watchdog limit.
  assign w_hung        = w_req_stb && !s_ack && !s_err;
  assign w_wd_fire     = WD_EN && w_hung && (r_wd_cnt == WD_LAST);
  assign w_wd_cnt_next = (WD_EN && w_hung && !w_wd_fire) ? r_wd_cnt + 1'b1 : '0;

  assign s_adr   = w_sel1 ? m1_adr   : m0_adr;
  assign s_dat_w = w_sel1 ? m1_dat_w : m0_dat_w;
  assign s_sel   = w_sel1 ? m1_sel   : m0_sel;
  assign s_we    = w_sel1 ? m1_we    : m0_we;
  assign s_cyc   = !rst && w_req_cyc && !w_wd_fire;
  assign s_stb   = !rst && w_req_stb && !w_wd_fire;

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = !rst && (r_state == GNT0) && s_ack;
  assign m0_err   = !rst && (r_state == GNT0) && (s_err || w_wd_fire);
  assign m1_ack   = !rst && (r_state == GNT1) && s_ack;
  assign m1_err   = !rst && (r_state == GNT1) && (s_err || w_wd_fire);

  assign gnt     = rst ? 2'b00 : {r_state == GNT1, r_state == GNT0};
  assign timeout = !rst && w_wd_fire;

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Self-checking bench for wb_arbiter_2x1: vector table, directed corner cases,
// and randomized traffic compared against a transaction-level reference model.
module tb_wb_arbiter_2x1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat_w, m1_dat_w, s_dat_w;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_we, m1_we, s_we;
  logic          m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [DW-1:0] m0_dat_r, m1_dat_r, s_dat_r;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_ack, s_err;
  logic [1:0]    gnt;
  logic          timeout;

  always #5 clk = ~clk;

  wb_arbiter_2x1 #(
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt), .timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // {gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, timeout}
  typedef struct packed {
    logic       c0;
    logic       s0;
    logic       c1;
    logic       s1;
    logic       ack;
    logic       err;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [8:0] ctrl_now();
    return {gnt, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, timeout};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic c0, input logic s0, input logic c1, input logic s1,
                         input logic ack, input logic err);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack; s_err = err;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_ctl(0, 0, 0, 0, 0, 0);
    m0_adr = '0; m1_adr = '0; m0_dat_w = '0; m1_dat_w = '0;
    m0_sel = '0; m1_sel = '0; m0_we = 1'b0; m1_we = 1'b0; s_dat_r = '0;
    next_cycle();
    next_cycle();
    #1;
    check("reset_outputs", 128'(ctrl_now()), 128'(9'b0));
    rst = 1'b0;
  endtask

  int         owner;
  int         last_w;
  int         waitc;
  int         new_owner;
  logic       cyc_a [2];
  logic       stb_a [2];
  logic       stbg, hung, fire;
  logic [8:0] exp_ctrl;
  logic [68:0] req_exp;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b00_00_0000_0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b01_11_1000_0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'b01_00_0000_0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'b10_11_0010_0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b10_10_0000_0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b10_11_0010_0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b10_11_0010_0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b10_00_0000_0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b01_11_1000_0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b01_00_0000_0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b00_00_0000_0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b10_11_0000_0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b10_00_0001_0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b00_00_0000_0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'b01_11_1100_0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b01_00_0000_0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_00_0000_0};

    // Vector table: ties, handoffs, locked multi-beat cycles, ack+err together.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_ctl(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err);
      #1;
      $display("vec %0d: ctrl=%b", i, ctrl_now());
      check($sformatf("vec%0d", i), 128'(ctrl_now()), 128'(tbl[i].exp));
      next_cycle();
    end

    // Single m0 read with data return.
    do_reset();
    m0_adr = 32'h1000_0040; s_dat_r = 32'hDEAD_BEEF;
    set_ctl(1, 1, 0, 0, 0, 0);
    #1;
    check("t1_idle_gnt", 128'(gnt), 128'(2'b00));
    next_cycle();
    check("t1_gnt", 128'(gnt), 128'(2'b01));
    check("t1_s_adr", 128'(s_adr), 128'(32'h1000_0040));
    next_cycle();
    s_ack = 1'b1;
    #1;
    check("t1_ack", 128'({m0_ack, m1_ack}), 128'(2'b10));
    check("t1_dat_r", 128'(m0_dat_r), 128'(32'hDEAD_BEEF));
    $display("t1: m0 read data=%h", m0_dat_r);
    next_cycle();
    set_ctl(0, 0, 0, 0, 0, 0);
    next_cycle();

    // Watchdog fires on the 16th hung strobe cycle, then restarts from zero.
    set_ctl(1, 1, 0, 0, 0, 0);
    next_cycle();
    for (int k = 1; k <= 32; k++) begin
      logic f;
      f = (k == 16) || (k == 32);
      #1;
      if (f) $display("t4: stb cycle %0d ctrl=%b", k, ctrl_now());
      check($sformatf("t4_wd_k%0d", k), 128'(ctrl_now()),
            128'({2'b01, !f, !f, 1'b0, f, 2'b00, f}));
      next_cycle();
    end
    set_ctl(0, 0, 0, 0, 0, 0);
    next_cycle();

    // Ack on the would-be firing cycle wins over the watchdog.
    set_ctl(1, 1, 0, 0, 0, 0);
    next_cycle();
    for (int k = 1; k <= 17; k++) begin
      s_ack = (k == 16);
      #1;
      check($sformatf("t5_k%0d", k), 128'(ctrl_now()),
            128'({2'b01, 2'b11, (k == 16), 4'b0000}));
      next_cycle();
    end
    $display("t5: ack at watchdog limit handled");
    set_ctl(0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reset in the middle of an m1 beat.
    do_reset();
    set_ctl(0, 0, 1, 1, 0, 0);
    next_cycle();
    #1;
    check("t6_gnt1", 128'(gnt), 128'(2'b10));
    next_cycle();
    rst = 1'b1; s_ack = 1'b1;
    #1;
    check("t6_rst_outputs", 128'(ctrl_now()), 128'(9'b0));
    next_cycle();
    rst = 1'b0;
    set_ctl(1, 1, 1, 1, 0, 0);
    #1;
    check("t6_idle_after", 128'(gnt), 128'(2'b00));
    next_cycle();
    #1;
    check("t6_tie_m0", 128'(gnt), 128'(2'b01));
    $display("t6: reset mid-beat, tie then granted gnt=%b", gnt);
    set_ctl(0, 0, 0, 0, 0, 0);
    next_cycle();

    // Random traffic against the reference model.
    do_reset();
    owner = -1; last_w = 1; waitc = 0;
    cyc_a[0] = 1'b0; cyc_a[1] = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bit slow;
      slow = ((i / 200) % 2) == 1;
      for (int m = 0; m < 2; m++) begin
        if (cyc_a[m]) cyc_a[m] = ($urandom_range(7) != 0);
        else          cyc_a[m] = ($urandom_range(3) == 0);
        stb_a[m] = cyc_a[m] && ($urandom_range(3) != 0);
      end
      m0_cyc = cyc_a[0]; m0_stb = stb_a[0]; m1_cyc = cyc_a[1]; m1_stb = stb_a[1];
      s_ack = slow ? ($urandom_range(49) == 0) : ($urandom_range(2) == 0);
      s_err = ($urandom_range(19) == 0);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat_w = $urandom; m1_dat_w = $urandom;
      m0_sel = SW'($urandom); m1_sel = SW'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom); s_dat_r = $urandom;
      #1;

      stbg = 1'b0; hung = 1'b0; fire = 1'b0; exp_ctrl = '0;
      if (owner >= 0) begin
        stbg = stb_a[owner];
        hung = stbg && !s_ack && !s_err;
        fire = hung && (waitc + 1 == TO);
        exp_ctrl = {(owner == 1), (owner == 0), cyc_a[owner] && !fire, stbg && !fire,
                    (owner == 0) && s_ack, (owner == 0) && (s_err || fire),
                    (owner == 1) && s_ack, (owner == 1) && (s_err || fire), fire};
        req_exp = (owner == 0) ? {m0_adr, m0_dat_w, m0_sel, m0_we}
                               : {m1_adr, m1_dat_w, m1_sel, m1_we};
        check($sformatf("rnd%0d_req", i), 128'({s_adr, s_dat_w, s_sel, s_we}), 128'(req_exp));
        if (s_ack || s_err || fire)
          $display("rnd %0d: m%0d ack=%0b err=%0b timeout=%0b", i, owner, s_ack, s_err, fire);
      end
      check($sformatf("rnd%0d_ctrl", i), 128'(ctrl_now()), 128'(exp_ctrl));
      check($sformatf("rnd%0d_dat_r", i), 128'({m0_dat_r, m1_dat_r}), 128'({s_dat_r, s_dat_r}));

      waitc = (owner >= 0 && hung && !fire) ? waitc + 1 : 0;
      if (owner < 0) begin
        if (cyc_a[0] && cyc_a[1]) new_owner = 1 - last_w;
        else if (cyc_a[0])        new_owner = 0;
        else if (cyc_a[1])        new_owner = 1;
        else                      new_owner = -1;
      end else if (!cyc_a[owner]) begin
        new_owner = cyc_a[1 - owner] ? 1 - owner : -1;
      end else begin
        new_owner = owner;
      end
      if (new_owner >= 0) last_w = new_owner;
      owner = new_owner;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
